clint: RTL and testbench

- Core-local interruptor: the source end of the interrupt lines that the CSR/trap unit consumes.
- Holds the memory-mapped msip, mtime and mtimecmp registers and answers data-bus requests from the memory stage.
- Drives `trint` (timer), `swint` (software) and `exint` (external) towards the CSR unit.
- Sits beside the data-bus arbiter and is selected by address.

---
 rtl/clint_pkg.sv | 27 ++
 rtl/sync2.sv | 22 ++
 rtl/clint.sv | 158 +++++++++++++++
 tb/tb_clint.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets inside
// the 64 KiB window, the bus-access FSM state type and the byte-lane merge.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } clint_state_e;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strobe);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strobe[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, async active-low reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip / mtimecmp / mtime registers behind a simple
// request/response data bus, plus the timer, software and external interrupt
// lines towards the CSR unit.
// Build option: define CLINT_EXT_SYNC_EN to pass ext_irq through a two-flop
// synchronizer (exint lags by 2 cycles); otherwise exint is a single
// registered copy (1-cycle lag).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for req_valid; request fields latched on acceptance
// ACCESS | decode latched address, perform store merge or capture load data
// RESP   | data_ok pulse with rdata/resp_err; req_valid ignored
module clint
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic        req_write,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_wdata,
  output logic        data_ok,
  output logic [63:0] rdata,
  output logic        resp_err,
  input  logic        ext_irq,
  output logic        trint,
  output logic        swint,
  output logic        exint
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  clint_state_e   state_q;
  logic [63:0]    addr_q;
  logic           write_q;
  logic [7:0]     strobe_q;
  logic [63:0]    wdata_q;

  logic           msip_q;
  logic [63:0]    mtimecmp_q;
  logic [63:0]    mtime_q;
  logic [TW-1:0]  tick_q;

  logic           in_win;
  logic           sel_msip;
  logic           sel_cmp;
  logic           sel_time;
  logic           sel_ok;
  logic [63:0]    rd_val;
  logic           mtime_wr;
  logic           tick_hit;

  // Address decode and read mux on the latched request.
  always_comb begin
    in_win   = (addr_q[63:16] == BASE_ADDR[63:16]);
    sel_msip = in_win && (addr_q[15:0] == CLINT_MSIP_OFF);
    sel_cmp  = in_win && (addr_q[15:0] == CLINT_MTIMECMP_OFF);
    sel_time = in_win && (addr_q[15:0] == CLINT_MTIME_OFF);
    sel_ok   = sel_msip || sel_cmp || sel_time;
    rd_val   = 64'd0;
    if (sel_msip)      rd_val = {63'd0, msip_q};
    else if (sel_cmp)  rd_val = mtimecmp_q;
    else if (sel_time) rd_val = mtime_q;
    mtime_wr = (state_q == ACCESS) && write_q && sel_time;
    tick_hit = (tick_q == TW'(TICK_DIV - 1));
  end

  // Bus FSM: latch request, perform access, issue one-cycle response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= 64'd0;
      write_q    <= 1'b0;
      strobe_q   <= 8'd0;
      wdata_q    <= 64'd0;
      data_ok    <= 1'b0;
      rdata      <= 64'd0;
      resp_err   <= 1'b0;
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            write_q  <= req_write;
            strobe_q <= req_strobe;
            wdata_q  <= req_wdata;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          data_ok <= 1'b1;
          if (!sel_ok) begin
            resp_err <= 1'b1;
            rdata    <= 64'd0;
          end else if (write_q) begin
            if (sel_msip && strobe_q[0]) msip_q <= wdata_q[0];
            if (sel_cmp) mtimecmp_q <= strb_merge(mtimecmp_q, wdata_q, strobe_q);
          end else begin
            rdata <= rd_val;
          end
        end
        RESP: begin
          data_ok  <= 1'b0;
          rdata    <= 64'd0;
          resp_err <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Time base: prescaler plus mtime; a bus store to mtime overrides the tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q  <= '0;
      mtime_q <= 64'd0;
    end else begin
      tick_q <= tick_hit ? '0 : tick_q + 1'b1;
      if (mtime_wr)      mtime_q <= strb_merge(mtime_q, wdata_q, strobe_q);
      else if (tick_hit) mtime_q <= mtime_q + 64'd1;
    end
  end

  // Timer and software interrupt lines, registered from current register values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trint <= 1'b0;
      swint <= 1'b0;
    end else begin
      trint <= (mtime_q >= mtimecmp_q);
      swint <= msip_q;
    end
  end

`ifdef CLINT_EXT_SYNC_EN
  sync2 u_ext_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ext_irq),
    .q     (exint)
  );
`else
  // External interrupt line, single registered copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) exint <= 1'b0;
    else        exint <= ext_irq;
  end
`endif

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: scoreboard of expected load responses,
// cycle-count model of mtime (TICK_DIV = 1), interrupt-line timing checks.
module tb_clint;

  localparam logic [63:0] A_MSIP = 64'h0200_0000;
  localparam logic [63:0] A_CMP  = 64'h0200_4000;
  localparam logic [63:0] A_TIME = 64'h0200_BFF8;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef CLINT_EXT_SYNC_EN
  localparam int EXT_LAG = 2;
`else
  localparam int EXT_LAG = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic        req_write = 1'b0;
  logic [7:0]  req_strobe = 8'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        data_ok;
  logic [63:0] rdata;
  logic        resp_err;
  logic        ext_irq = 1'b0;
  logic        trint;
  logic        swint;
  logic        exint;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [63:0] cyc;
  logic [63:0] base_val = 64'd0;
  logic [63:0] base_cyc = 64'd0;

  always #5 clk = ~clk;

  clint #(.BASE_ADDR(64'h0200_0000), .TICK_DIV(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_strobe (req_strobe),
    .req_wdata  (req_wdata),
    .data_ok    (data_ok),
    .rdata      (rdata),
    .resp_err   (resp_err),
    .ext_irq    (ext_irq),
    .trint      (trint),
    .swint      (swint),
    .exint      (exint)
  );

  // Rising edges seen while out of reset; mtime advances once per edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 64'd0;
    else        cyc <= cyc + 64'd1;
  end

  function automatic logic [63:0] m_now();
    return base_val + (cyc - base_cyc);
  endfunction

  function automatic logic [63:0] tb_merge(input logic [63:0] o, input logic [63:0] n,
                                           input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // One bus transaction from an IDLE-cycle negedge; returns at the negedge of
  // the IDLE cycle after the response. Loads of mtime take their expectation
  // from the cycle model; exp_rd is used otherwise.
  task automatic bus_op(input string name, input logic [63:0] addr, input logic wr,
                        input logic [7:0] strb, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_err);
    exp_t e;
    exp_t got;
    int k;
    logic [63:0] newval;
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_strobe = strb; req_wdata = wd;
    @(negedge clk); k = 1;
    checks++;
    if (data_ok !== 1'b0) begin
      errors++; $display("FAIL %s early_ok: data_ok=%b required 0", name, data_ok);
    end
    e.rd = (addr == A_TIME && !wr) ? m_now() : exp_rd;
    e.err = exp_err;
    newval = tb_merge(m_now(), wd, strb);
    sb.push_back(e);
    @(negedge clk); k = 2;
    if (addr == A_TIME && wr) begin base_val = newval; base_cyc = cyc; end
    while (data_ok !== 1'b1 && k < 8) begin @(negedge clk); k++; end
    got = sb.pop_front();
    checks++;
    if (data_ok !== 1'b1) begin
      errors++; $display("FAIL %s timeout: no data_ok within %0d cycles", name, k);
    end else if (k != 2) begin
      errors++; $display("FAIL %s latency: got %0d cycles required 2", name, k);
    end
    if (data_ok === 1'b1) begin
      checks++;
      if (rdata !== got.rd || resp_err !== got.err) begin
        errors++;
        $display("FAIL %s resp: rdata=%h err=%b required rdata=%h err=%b",
                 name, rdata, resp_err, got.rd, got.err);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (data_ok !== 1'b0 || rdata !== 64'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: data_ok=%b rdata=%h err=%b required 0/0/0",
               name, data_ok, rdata, resp_err);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({data_ok, rdata, resp_err, trint, swint, exint} !== 68'd0) begin
      errors++;
      $display("FAIL reset_outs: ok=%b rd=%h err=%b t=%b s=%b e=%b required all 0",
               data_ok, rdata, resp_err, trint, swint, exint);
    end
    reset = 1'b1; base_val = 64'd0; base_cyc = 64'd0;
    @(negedge clk);
    bus_op("rst_cmp", A_CMP, 1'b0, 8'h00, 64'd0, ONES, 1'b0);
    bus_op("rst_msip", A_MSIP, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
    bus_op("rst_time", A_TIME, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
    checks++;
    if (trint !== 1'b0) begin errors++; $display("FAIL rst_trint: got %b required 0", trint); end
  endtask

  task automatic test_msip();
    bus_op("sw_set", A_MSIP, 1'b1, 8'h01, 64'h1, 64'd0, 1'b0);
    checks++;
    if (swint !== 1'b1) begin errors++; $display("FAIL sw_set_line: got %b required 1", swint); end
    bus_op("sw_rd1", A_MSIP, 1'b0, 8'h00, 64'd0, 64'h1, 1'b0);
    bus_op("sw_ones", A_MSIP, 1'b1, 8'hFF, ONES, 64'd0, 1'b0);
    bus_op("sw_rd_hi0", A_MSIP, 1'b0, 8'h00, 64'd0, 64'h1, 1'b0);
    bus_op("sw_clr", A_MSIP, 1'b1, 8'h01, 64'h0, 64'd0, 1'b0);
    checks++;
    if (swint !== 1'b0) begin errors++; $display("FAIL sw_clr_line: got %b required 0", swint); end
    bus_op("sw_nostrb", A_MSIP, 1'b1, 8'hFE, ONES, 64'd0, 1'b0);
    checks++;
    if (swint !== 1'b0) begin errors++; $display("FAIL sw_nostrb_line: got %b required 0", swint); end
    bus_op("sw_rd0", A_MSIP, 1'b0, 8'h00, 64'd0, 64'h0, 1'b0);
  endtask

  task automatic test_timer();
    int i;
    bus_op("tm_time0", A_TIME, 1'b1, 8'hFF, 64'd0, 64'd0, 1'b0);
    bus_op("tm_cmp20", A_CMP, 1'b1, 8'hFF, 64'd20, 64'd0, 1'b0);
    checks++;
    if (trint !== 1'b0) begin errors++; $display("FAIL tm_early: got %b required 0", trint); end
    i = 0;
    while (m_now() != 64'd20 && i < 64) begin @(negedge clk); i++; end
    checks++;
    if (m_now() != 64'd20) begin
      errors++; $display("FAIL tm_wait: model mtime %0d never reached 20", m_now());
    end else if (trint !== 1'b0) begin
      errors++; $display("FAIL tm_at20: got %b required 0", trint);
    end
    @(negedge clk);
    checks++;
    if (trint !== 1'b1) begin errors++; $display("FAIL tm_fire: got %b required 1", trint); end
    bus_op("tm_cmp_rd", A_CMP, 1'b0, 8'h00, 64'd0, 64'd20, 1'b0);
    bus_op("tm_cmp_ones", A_CMP, 1'b1, 8'hFF, ONES, 64'd0, 1'b0);
    checks++;
    if (trint !== 1'b0) begin errors++; $display("FAIL tm_clear: got %b required 0", trint); end
  endtask

  task automatic test_wrap();
    bus_op("wr_store", A_TIME, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0);
    bus_op("wr_rd1", A_TIME, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
    bus_op("wr_rd2", A_TIME, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
    bus_op("wr_part", A_TIME, 1'b1, 8'h0F, 64'hAAAA_AAAA_1234_5678, 64'd0, 1'b0);
    bus_op("wr_rd3", A_TIME, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
    bus_op("cmp_part", A_CMP, 1'b1, 8'hF0, 64'd0, 64'd0, 1'b0);
    bus_op("cmp_part_rd", A_CMP, 1'b0, 8'h00, 64'd0, 64'h0000_0000_FFFF_FFFF, 1'b0);
    bus_op("cmp_restore", A_CMP, 1'b1, 8'hFF, ONES, 64'd0, 1'b0);
  endtask

  task automatic test_bad_addr();
    bus_op("bad_ld", 64'h0200_1000, 1'b0, 8'h00, 64'd0, 64'd0, 1'b1);
    bus_op("bad_st", 64'h0200_1000, 1'b1, 8'hFF, 64'h5, 64'd0, 1'b1);
    bus_op("bad_win", 64'h0300_4000, 1'b1, 8'hFF, 64'd0, 64'd0, 1'b1);
    bus_op("bad_mis", 64'h0200_BFF0, 1'b1, 8'hFF, 64'd0, 64'd0, 1'b1);
    bus_op("bad_chk_msip", A_MSIP, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
    bus_op("bad_chk_cmp", A_CMP, 1'b0, 8'h00, 64'd0, ONES, 1'b0);
    bus_op("bad_chk_time", A_TIME, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic test_ext();
    checks++;
    if (exint !== 1'b0) begin errors++; $display("FAIL ext_idle: got %b required 0", exint); end
    ext_irq = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (exint !== (k == EXT_LAG)) begin
        errors++; $display("FAIL ext_lag%0d: got %b required %b", k, exint, (k == EXT_LAG));
      end
      ext_irq = 1'b0;
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    req_valid = 1'b1; req_addr = A_MSIP; req_write = 1'b1; req_strobe = 8'h01; req_wdata = 64'h1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({data_ok, rdata, resp_err, trint, swint, exint} !== 68'd0) begin
      errors++;
      $display("FAIL midop_outs: ok=%b rd=%h err=%b t=%b s=%b e=%b required all 0",
               data_ok, rdata, resp_err, trint, swint, exint);
    end
    req_valid = 1'b0;
    seen = 0;
    repeat (2) begin @(negedge clk); if (data_ok === 1'b1) seen++; end
    reset = 1'b1; base_val = 64'd0; base_cyc = 64'd0;
    repeat (4) begin @(negedge clk); if (data_ok === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midop_ok: got %0d pulses required 0", seen); end
    bus_op("midop_msip", A_MSIP, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
    checks++;
    if (swint !== 1'b0) begin errors++; $display("FAIL midop_swint: got %b required 0", swint); end
    bus_op("midop_time", A_TIME, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_msip();
    test_timer();
    test_wrap();
    test_bad_addr();
    test_ext();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
